// File: rtl/vx_hpdc_pkg.sv
// Shared types for the HPDCache request tracker: flush FSM states,
// per-entry tracking state and the tag-to-depth derivation.
package vx_hpdc_pkg;

  // Flush sequencing states. RUN is the only state that accepts new requests.
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_ISSUE = 2'd2,
    ST_WAIT  = 2'd3
  } flush_state_e;

  // Default data width used by the full entry view below.
  localparam int unsigned HPDC_DATA_WIDTH = 32;

  // Control bits of one tracker entry. The data half lives in vx_hpdc_rob_mem.
  typedef struct packed {
    logic pending;  // tag allocated, response not yet retired
    logic valid;    // response captured, waiting to be returned in order
  } entry_ctl_t;

  // Complete logical view of one tracker entry at the default data width.
  typedef struct packed {
    logic                       pending;
    logic                       valid;
    logic [HPDC_DATA_WIDTH-1:0] data;
  } tracker_entry_t;

  // Number of tracker entries addressable by a tag of the given width.
  function automatic int unsigned depth_of(input int unsigned tag_width);
    return 32'd1 << tag_width;
  endfunction

endpackage

// File: rtl/vx_hpdc_rob_mem.sv
// Response data storage for the tracker: one write port used when an
// adapter response is captured, one asynchronous read port at ret_ptr.
module vx_hpdc_rob_mem
  import vx_hpdc_pkg::*;
#(
  parameter int TAG_WIDTH  = 3,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [TAG_WIDTH-1:0]  wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [TAG_WIDTH-1:0]  rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = int'(depth_of(TAG_WIDTH));

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Capture write; contents need no reset because valid bits gate every read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/vx_hpdc_req_tracker.sv
// In-order request tracker between the Vortex core memory port and the
// HPDCache adapter. Tags every request, collects out-of-order responses by
// tag and returns them in issue order; sequences drain-then-flush.
//
// Handshake rule on every valid/ready pair here: a transfer happens in the
// cycle where both valid and ready are high at the rising clock edge; valid
// never depends on ready of the same interface. dn_rsp has no ready and is
// always consumed (captured or flagged as unexpected).
module vx_hpdc_req_tracker
  import vx_hpdc_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  // core request
  input  logic                  core_req_valid,
  output logic                  core_req_ready,
  input  logic                  core_req_rw,
  input  logic [ADDR_WIDTH-1:0] core_req_addr,
  input  logic [DATA_WIDTH-1:0] core_req_data,
  // core response
  output logic                  core_rsp_valid,
  input  logic                  core_rsp_ready,
  output logic [DATA_WIDTH-1:0] core_rsp_data,
  // core flush
  input  logic                  core_flush_req,
  output logic                  core_flush_done,
  // adapter request
  output logic                  dn_req_valid,
  input  logic                  dn_req_ready,
  output logic                  dn_req_rw,
  output logic [ADDR_WIDTH-1:0] dn_req_addr,
  output logic [DATA_WIDTH-1:0] dn_req_data,
  output logic [TAG_WIDTH-1:0]  dn_req_tag,
  // adapter response
  input  logic                  dn_rsp_valid,
  input  logic [TAG_WIDTH-1:0]  dn_rsp_tag,
  input  logic [DATA_WIDTH-1:0] dn_rsp_data,
  // adapter flush
  output logic                  dn_flush_valid,
  input  logic                  dn_flush_ready,
  input  logic                  dn_flush_done,
  // status
  output logic [TAG_WIDTH:0]    outstanding,
  output logic                  err_unexpected_rsp,
  output flush_state_e          dbg_flush_state
);

  localparam int                 DEPTH     = int'(depth_of(TAG_WIDTH));
  localparam logic [TAG_WIDTH:0] DEPTH_CNT = (TAG_WIDTH + 1)'(DEPTH);
  localparam logic [TAG_WIDTH:0] CNT_ONE   = (TAG_WIDTH + 1)'(1);
  localparam logic [TAG_WIDTH-1:0] PTR_ONE = TAG_WIDTH'(1);

  flush_state_e          state;
  logic [TAG_WIDTH-1:0]  alloc_ptr;
  logic [TAG_WIDTH-1:0]  ret_ptr;
  logic [TAG_WIDTH:0]    count;
  entry_ctl_t            ctl [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data;

  logic in_run;
  logic full;
  logic fire;
  logic retire;
  logic rsp_hit;
  logic capture;

  assign in_run  = (state == ST_RUN);
  assign full    = (count == DEPTH_CNT);

  // Request path is a straight pass-through gated by FSM state and occupancy.
  assign dn_req_valid   = core_req_valid & in_run & ~full;
  assign core_req_ready = dn_req_ready & in_run & ~full;
  assign fire           = dn_req_valid & dn_req_ready;
  assign dn_req_rw      = core_req_rw;
  assign dn_req_addr    = core_req_addr;
  assign dn_req_data    = core_req_data;
  assign dn_req_tag     = alloc_ptr;

  // A response is only legal for a tag that is allocated and not yet answered.
  assign rsp_hit = ctl[dn_rsp_tag].pending & ~ctl[dn_rsp_tag].valid;
  assign capture = dn_rsp_valid & rsp_hit;

  // Return side reads the registered valid bit, so capture never bypasses.
  assign core_rsp_valid = ctl[ret_ptr].valid;
  assign core_rsp_data  = core_rsp_valid ? rd_data : '0;
  assign retire         = core_rsp_valid & core_rsp_ready;

  assign outstanding     = count;
  assign dn_flush_valid  = (state == ST_ISSUE);
  assign core_flush_done = (state == ST_WAIT) & dn_flush_done;
  assign dbg_flush_state = state;

  vx_hpdc_rob_mem #(
    .TAG_WIDTH  (TAG_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rob_mem (
    .clk     (clk),
    .wr_en   (capture),
    .wr_addr (dn_rsp_tag),
    .wr_data (dn_rsp_data),
    .rd_addr (ret_ptr),
    .rd_data (rd_data)
  );

  // Per-entry pending/valid bookkeeping: allocate, capture, retire.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctl[i] <= '0;
      end
    end else begin
      if (fire) begin
        ctl[alloc_ptr].pending <= 1'b1;
      end
      if (capture) begin
        ctl[dn_rsp_tag].valid <= 1'b1;
      end
      if (retire) begin
        ctl[ret_ptr] <= '0;
      end
    end
  end

  // Allocation/return pointers and the live entry count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alloc_ptr <= '0;
      ret_ptr   <= '0;
      count     <= '0;
    end else begin
      if (fire) begin
        alloc_ptr <= alloc_ptr + PTR_ONE;
      end
      if (retire) begin
        ret_ptr <= ret_ptr + PTR_ONE;
      end
      unique case ({fire, retire})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Sticky flag for responses that match no waiting entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_unexpected_rsp <= 1'b0;
    end else if (dn_rsp_valid && !rsp_hit) begin
      err_unexpected_rsp <= 1'b1;
    end
  end

  // Flush sequencer: stop intake, drain, issue flush, wait for completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_RUN;
    end else begin
      unique case (state)
        ST_RUN:   if (core_flush_req) state <= ST_DRAIN;
        ST_DRAIN: if (count == '0)    state <= ST_ISSUE;
        ST_ISSUE: if (dn_flush_ready) state <= ST_WAIT;
        ST_WAIT:  if (dn_flush_done)  state <= ST_RUN;
        default:                      state <= ST_RUN;
      endcase
    end
  end

  // Allocation and retirement of the same entry can only coincide when full,
  // and allocation is blocked when full, so this must never be seen.
  a_no_same_entry: assert property (@(posedge clk) disable iff (reset)
    !(fire && retire && (alloc_ptr == ret_ptr)));

  // An allocated tag must be free.
  a_alloc_free: assert property (@(posedge clk) disable iff (reset)
    fire |-> !ctl[alloc_ptr].pending);

endmodule

// File: tb/tb_vx_hpdc_req_tracker.sv
// Bench for vx_hpdc_req_tracker: directed vectors, scoreboard queues for
// forwarded requests and in-order responses, monitors compare on handshakes.
module tb_vx_hpdc_req_tracker;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TW = 3;
  localparam int RW = 1 + AW + TW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          core_req_valid, core_req_ready, core_req_rw;
  logic [AW-1:0] core_req_addr;
  logic [DW-1:0] core_req_data;
  logic          core_rsp_valid, core_rsp_ready;
  logic [DW-1:0] core_rsp_data;
  logic          core_flush_req, core_flush_done;
  logic          dn_req_valid, dn_req_ready, dn_req_rw;
  logic [AW-1:0] dn_req_addr;
  logic [DW-1:0] dn_req_data;
  logic [TW-1:0] dn_req_tag;
  logic          dn_rsp_valid;
  logic [TW-1:0] dn_rsp_tag;
  logic [DW-1:0] dn_rsp_data;
  logic          dn_flush_valid, dn_flush_ready, dn_flush_done;
  logic [TW:0]   outstanding;
  logic          err_unexpected_rsp;
  logic [1:0]    dbg_flush_state;

  vx_hpdc_req_tracker #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
    .clk(clk), .reset(reset),
    .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
    .core_req_rw(core_req_rw), .core_req_addr(core_req_addr), .core_req_data(core_req_data),
    .core_rsp_valid(core_rsp_valid), .core_rsp_ready(core_rsp_ready), .core_rsp_data(core_rsp_data),
    .core_flush_req(core_flush_req), .core_flush_done(core_flush_done),
    .dn_req_valid(dn_req_valid), .dn_req_ready(dn_req_ready), .dn_req_rw(dn_req_rw),
    .dn_req_addr(dn_req_addr), .dn_req_data(dn_req_data), .dn_req_tag(dn_req_tag),
    .dn_rsp_valid(dn_rsp_valid), .dn_rsp_tag(dn_rsp_tag), .dn_rsp_data(dn_rsp_data),
    .dn_flush_valid(dn_flush_valid), .dn_flush_ready(dn_flush_ready), .dn_flush_done(dn_flush_done),
    .outstanding(outstanding), .err_unexpected_rsp(err_unexpected_rsp),
    .dbg_flush_state(dbg_flush_state)
  );

  // ---------------- scoreboard ----------------
  int tests_run = 0;
  int tests_failed = 0;
  int flush_pulses = 0;
  logic [DW-1:0] exp_q[$];
  logic [RW-1:0] exp_req_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitors sample mid-cycle; inputs only change just after rising edges.
  always @(negedge clk) begin
    logic [DW-1:0] e;
    logic [RW-1:0] er;
    if (!reset && core_rsp_valid && core_rsp_ready) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL rsp_unexpected: got data %0h, none expected", core_rsp_data);
      end else begin
        e = exp_q.pop_front();
        if (core_rsp_data !== e) begin
          tests_failed++;
          $display("FAIL rsp_data: got %0h, expected %0h", core_rsp_data, e);
        end
      end
    end
    if (!reset && dn_req_valid && dn_req_ready) begin
      tests_run++;
      if (exp_req_q.size() == 0) begin
        tests_failed++;
        $display("FAIL req_unexpected: got tag %0d addr %0h, none expected", dn_req_tag, dn_req_addr);
      end else begin
        er = exp_req_q.pop_front();
        if ({dn_req_rw, dn_req_addr, dn_req_tag} !== er) begin
          tests_failed++;
          $display("FAIL req_fwd: got rw/addr/tag %0h, expected %0h",
                   {dn_req_rw, dn_req_addr, dn_req_tag}, er);
        end
      end
    end
    if (!reset && core_flush_done) flush_pulses++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit check_outputs);
    reset = 1'b1;
    core_req_valid = 1'b0; core_req_rw = 1'b0; core_req_addr = '0; core_req_data = '0;
    core_rsp_ready = 1'b0; core_flush_req = 1'b0;
    dn_req_ready = 1'b0; dn_rsp_valid = 1'b0; dn_rsp_tag = '0; dn_rsp_data = '0;
    dn_flush_ready = 1'b0; dn_flush_done = 1'b0;
    exp_q.delete();
    exp_req_q.delete();
    @(negedge clk);
    if (check_outputs) begin
      check("rst_outstanding", outstanding, 0);
      check("rst_state", dbg_flush_state, 0);
      check("rst_outputs",
            {core_req_ready, core_rsp_valid, core_rsp_data, core_flush_done, dn_req_valid,
             dn_req_rw, dn_req_addr, dn_req_data, dn_req_tag, dn_flush_valid, err_unexpected_rsp}, 0);
    end
    tick();
    reset = 1'b0;
    dn_req_ready = 1'b1;
    core_rsp_ready = 1'b1;
    tick();
  endtask

  // Issue one request; expected forward and response go to the scoreboard first.
  task automatic issue_req(input logic rw, input logic [AW-1:0] addr, input logic [TW-1:0] tag,
                           input logic [DW-1:0] rsp);
    bit done = 0;
    exp_req_q.push_back({rw, addr, tag});
    exp_q.push_back(rsp);
    core_req_valid = 1'b1; core_req_rw = rw; core_req_addr = addr; core_req_data = addr ^ 32'h5a5a;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (core_req_ready) done = 1;
      tick();
    end
    core_req_valid = 1'b0;
    if (!done) begin
      check("req_accept_timeout", 0, 1);
      void'(exp_req_q.pop_back());
      void'(exp_q.pop_back());
    end
  endtask

  task automatic respond(input logic [TW-1:0] tag, input logic [DW-1:0] data);
    dn_rsp_valid = 1'b1; dn_rsp_tag = tag; dn_rsp_data = data;
    tick();
    dn_rsp_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && outstanding != 0; i++) begin
      @(negedge clk);
    end
    check("drain_outstanding", outstanding, 0);
    tick();
  endtask

  task automatic pulse_flush();
    core_flush_req = 1'b1;
    tick();
    core_flush_req = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit seen;
    do_reset(1);

    // In-order return
    issue_req(0, 32'h100, 0, 32'hAAAA);
    issue_req(0, 32'h104, 1, 32'hBBBB);
    @(negedge clk);
    check("inorder_outstanding2", outstanding, 2);
    tick();
    respond(0, 32'hAAAA);
    respond(1, 32'hBBBB);
    wait_idle();

    // Out-of-order capture, in-order return
    do_reset(0);
    for (int i = 0; i < 4; i++) issue_req(0, 32'h200 + 4 * i, TW'(i), DW'(i));
    respond(3, 32'h3);
    respond(1, 32'h1);
    respond(2, 32'h2);
    @(negedge clk);
    check("reorder_hold", core_rsp_valid, 0);
    tick();
    respond(0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("reorder_back2back", core_rsp_valid, 1);
    end
    tick();
    wait_idle();

    // Full and wrap
    do_reset(0);
    for (int r = 0; r < 8; r++) issue_req(0, 32'h1000 + 4 * r, TW'(r), 32'h1000 + r);
    core_req_valid = 1'b1; core_req_addr = 32'hFFF0;
    @(negedge clk);
    check("full_ready", core_req_ready, 0);
    check("full_dn_valid", dn_req_valid, 0);
    check("full_outstanding", outstanding, 8);
    tick();
    core_req_valid = 1'b0;
    respond(0, 32'h1000);
    issue_req(0, 32'h1000 + 4 * 8, 0, 32'h1000 + 8);
    core_req_valid = 1'b1; core_req_addr = 32'hFFF4;
    @(negedge clk);
    check("refill_one_ready", core_req_ready, 0);
    check("refill_one_outstanding", outstanding, 8);
    tick();
    core_req_valid = 1'b0;
    for (int r = 9; r < 20; r++) begin
      respond(TW'(r - 8), 32'h1000 + r - 8);
      issue_req(0, 32'h1000 + 4 * r, TW'(r), 32'h1000 + r);
    end
    for (int r = 12; r < 20; r++) respond(TW'(r), 32'h1000 + r);
    wait_idle();

    // Flush sequencing
    do_reset(0);
    issue_req(0, 32'h300, 0, 32'hA0);
    exp_req_q.push_back({1'b0, 32'h304, 3'd1});
    exp_q.push_back(32'hA1);
    core_req_valid = 1'b1; core_req_addr = 32'h304; core_flush_req = 1'b1;
    @(negedge clk);
    check("flush_same_cycle_accept", core_req_ready, 1);
    tick();
    core_flush_req = 1'b0;
    exp_req_q.push_back({1'b0, 32'h308, 3'd2});
    exp_q.push_back(32'hA2);
    core_req_addr = 32'h308;
    @(negedge clk);
    check("flush_state_drain", dbg_flush_state, 1);
    check("flush_req_stalled", core_req_ready, 0);
    check("flush_no_issue_early", dn_flush_valid, 0);
    tick();
    respond(0, 32'hA0);
    @(negedge clk);
    check("flush_wait_drain", dn_flush_valid, 0);
    tick();
    respond(1, 32'hA1);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (dn_flush_valid) seen = 1;
    end
    check("flush_issue_seen", seen, 1);
    check("flush_issue_stalled", core_req_ready, 0);
    tick();
    dn_flush_ready = 1'b1;
    tick();
    dn_flush_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("flush_wait_nodone", {dn_flush_valid, core_flush_done}, 0);
      tick();
    end
    dn_flush_done = 1'b1;
    @(negedge clk);
    check("flush_done_pulse", core_flush_done, 1);
    tick();
    dn_flush_done = 1'b0;
    @(negedge clk);
    check("flush_done_single", core_flush_done, 0);
    check("flush_resume_ready", core_req_ready, 1);
    tick();
    core_req_valid = 1'b0;
    respond(2, 32'hA2);
    wait_idle();
    check("flush_pulse_count", flush_pulses, 1);

    // Unexpected responses
    do_reset(0);
    @(negedge clk);
    check("err_clear", err_unexpected_rsp, 0);
    tick();
    respond(5, 32'hDEAD);
    @(negedge clk);
    check("err_stray_tag", err_unexpected_rsp, 1);
    check("err_stray_no_rsp", core_rsp_valid, 0);
    check("err_stray_outstanding", outstanding, 0);
    tick();
    repeat (3) tick();
    @(negedge clk);
    check("err_sticky", err_unexpected_rsp, 1);
    tick();
    do_reset(0);
    core_rsp_ready = 1'b0;
    issue_req(0, 32'h400, 0, 32'h55);
    respond(0, 32'h55);
    @(negedge clk);
    check("dup_err_before", err_unexpected_rsp, 0);
    tick();
    respond(0, 32'h66);
    @(negedge clk);
    check("dup_err", err_unexpected_rsp, 1);
    check("dup_data_kept", {core_rsp_valid, core_rsp_data}, {1'b1, 32'h55});
    tick();
    core_rsp_ready = 1'b1;
    wait_idle();
    check("dup_err_sticky", err_unexpected_rsp, 1);

    // Reset in the middle of a drain
    do_reset(0);
    for (int i = 0; i < 3; i++) issue_req(0, 32'h500 + 4 * i, TW'(i), 32'h50 + i);
    pulse_flush();
    @(negedge clk);
    check("midrst_in_drain", dbg_flush_state, 1);
    check("midrst_outstanding3", outstanding, 3);
    tick();
    do_reset(1);
    issue_req(0, 32'h600, 0, 32'h77);
    respond(0, 32'h77);
    wait_idle();
    respond(1, 32'h11);
    @(negedge clk);
    check("midrst_stale_rsp_err", err_unexpected_rsp, 1);
    tick();

    check("final_rsp_queue_empty", exp_q.size(), 0);
    check("final_req_queue_empty", exp_req_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vx_hpdc_req_tracker.md
Name: vx_hpdc_req_tracker

Overview:
- In-order request tracker between the Vortex core memory port (upstream) and the HPDCache interface adapter (downstream).
- Allocates a tag to every core request and forwards it to the adapter.
- Captures out-of-order adapter responses by tag and returns them to the core strictly in issue order.
- Sequences cache flushes: drains outstanding requests, then issues the flush downstream and waits for its completion.

Parameters:
- ADDR_WIDTH, 32, request address width.
- DATA_WIDTH, 32, request/response data width.
- TAG_WIDTH, 3, downstream tag width; tracker depth DEPTH = 2**TAG_WIDTH.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- core_req_valid  in  1  core request valid
- core_req_ready  out  1  core request accepted
- core_req_rw  in  1  1=write, 0=read
- core_req_addr  in  ADDR_WIDTH  request address
- core_req_data  in  DATA_WIDTH  write data
- core_rsp_valid  out  1  in-order response valid
- core_rsp_ready  in  1  core accepts response
- core_rsp_data  out  DATA_WIDTH  read data (0 for write acks)
- core_flush_req  in  1  flush request, sampled only in RUN
- core_flush_done  out  1  one-cycle pulse on flush completion
- dn_req_valid  out  1  request to adapter
- dn_req_ready  in  1  adapter ready
- dn_req_rw  out  1  forwarded rw
- dn_req_addr  out  ADDR_WIDTH  forwarded address
- dn_req_data  out  DATA_WIDTH  forwarded data
- dn_req_tag  out  TAG_WIDTH  allocated tag
- dn_rsp_valid  in  1  adapter response; always accepted, no ready
- dn_rsp_tag  in  TAG_WIDTH  response tag
- dn_rsp_data  in  DATA_WIDTH  response data
- dn_flush_valid  out  1  flush command to adapter
- dn_flush_ready  in  1  flush command accepted
- dn_flush_done  in  1  adapter flush complete
- outstanding  out  TAG_WIDTH+1  live entry count
- err_unexpected_rsp  out  1  sticky protocol error

Behaviour:
- Reset values: all outputs 0.
- Reset clears alloc_ptr, ret_ptr, count, all entry pending/valid bits, the FSM (to RUN) and the error flag.
- Reset mid-operation discards all outstanding entries; responses arriving afterwards for those tags raise err_unexpected_rsp.
- Entry state:
  - pending[i] set on allocation.
  - valid[i] set when the response is captured.
  - Both bits clear on retirement.
  - data[i] is DATA_WIDTH storage.
- Request path (combinational pass-through, no added latency):
  - dn_req_valid = core_req_valid & state==RUN & count<DEPTH.
  - core_req_ready = dn_req_ready & state==RUN & count<DEPTH.
  - dn_req_tag = alloc_ptr.
  - Fire = dn_req_valid & dn_req_ready: sets pending[alloc_ptr] and increments alloc_ptr, wrapping modulo DEPTH.
- Response capture:
  - When dn_rsp_valid and pending[tag] & ~valid[tag]: store data and set valid[tag].
  - Otherwise the response is dropped and err_unexpected_rsp is set (sticky until reset).
- Response return:
  - core_rsp_valid = valid[ret_ptr]; core_rsp_data = data[ret_ptr].
  - A response captured in cycle N is visible at the core in cycle N+1 at earliest; there is no same-cycle bypass.
  - On core_rsp_valid & core_rsp_ready: clear pending/valid[ret_ptr] and increment ret_ptr, wrapping.
- Count:
  - +1 on request fire, −1 on retire; simultaneous fire and retire leaves count unchanged.
  - Full at count==DEPTH: core_req_ready=0.
  - Empty at count==0.
  - outstanding = count.
- Same-entry edge case: retiring entry k and allocating entry k in the same cycle is legal only when count==DEPTH. Allocation is blocked when full, so this cannot occur; assert it never happens.
- Flush FSM states RUN, DRAIN, ISSUE, WAIT:
  - RUN: core_flush_req=1 → DRAIN. New requests are blocked from the next cycle; a request firing in the same cycle as core_flush_req is still accepted.
  - DRAIN: count==0 → ISSUE. Responses continue to drain to the core.
  - ISSUE: dn_flush_valid=1; dn_flush_ready → WAIT.
  - WAIT: dn_flush_done → RUN, with core_flush_done pulsing for 1 cycle in the transition cycle.
  - core_flush_req outside RUN is ignored.
  - dn_flush_done outside WAIT is ignored.
- Arithmetic: pointers are TAG_WIDTH bits with natural wrap; count is TAG_WIDTH+1 bits.

Decomposition:
- Shared package vx_hpdc_pkg holds:
  - flush FSM state enum
  - tracker entry struct {pending, valid, data}
  - the DEPTH localparam derivation
- One sub-module: vx_hpdc_rob_mem, the DEPTH×DATA_WIDTH storage with one write port (capture) and one async read port (ret_ptr).
- FSM and pointers stay in the top module.

Test Plan:
- In-order: issue reads at addr 0x100, 0x104 (tags 0, 1); respond tag0=0xAAAA then tag1=0xBBBB → core sees 0xAAAA then 0xBBBB, outstanding returns to 0.
- Reorder: issue 4 reads (tags 0–3); respond tags 3, 1, 2, 0 with data 0x3, 0x1, 0x2, 0x0 → core_rsp_valid stays low until tag0 arrives, then the core receives 0x0, 0x1, 0x2, 0x3 on consecutive cycles with core_rsp_ready=1.
- Full/wrap:
  - Issue 8 requests with no responses → core_req_ready=0 and outstanding=8.
  - Respond and retire tag0 → exactly one new request is accepted with tag 0.
  - Run 20 requests total → tags wrap correctly.
- Flush:
  - With 2 requests outstanding, assert core_flush_req → the next core request is stalled and dn_flush_valid stays 0 until both responses retire.
  - dn_flush_valid then asserts; after dn_flush_ready followed 3 cycles later by dn_flush_done → core_flush_done pulses once and requests resume.
- Error: dn_rsp_valid with tag 5 while tag 5 is not pending, and a duplicate response to tag 0 → err_unexpected_rsp=1 and sticky; core output unaffected.
- Reset mid-operation: assert reset with 3 outstanding and the FSM in DRAIN → all outputs 0, FSM in RUN, outstanding=0; the first request after reset gets tag 0.
